// File: rtl/trace_uart_tx.sv
// Retired-instruction trace (PC + instruction word) buffered in a small FIFO
// and shipped off-chip as eight 8N1 bytes per entry, most significant byte first.
module trace_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8,
   parameter int ADDR_W       = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trace_valid,
   input  logic [31:0]       trace_pc,
   input  logic [31:0]       trace_instr,
   output logic              tx,
   output logic              busy,
   output logic              overflow,
   output logic [ADDR_W:0]   fifo_count
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t state, state_n;
   logic [BW-1:0] baud, baud_n;
   logic [2:0] bit_idx, bit_n;
   logic [2:0] byte_idx, byte_n;
   logic [63:0] shreg, shreg_n;
   logic tx_d, baud_done;

   logic [63:0] mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic full, empty, push, pop;

   assign full  = (fifo_count == DEPTH);
   assign empty = (fifo_count == '0);
   assign push  = trace_valid && !full;
   assign busy  = (state != IDLE) || !empty;
   assign baud_done = (baud == BAUD_MAX);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {trace_pc, trace_instr};
   end

   // Full is sampled before this edge's pop, so a push at full is always dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_count <= fifo_count + 1'b1;
         else if (pop && !push) fifo_count <= fifo_count - 1'b1;
         if (trace_valid && full) overflow <= 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      baud_n  = baud;
      bit_n   = bit_idx;
      byte_n  = byte_idx;
      shreg_n = shreg;
      pop     = 1'b0;
      tx_d    = 1'b1;
      unique case (state)
         IDLE: begin
            baud_n = '0;
            if (!empty) begin
               pop     = 1'b1;
               shreg_n = mem[rd_ptr];
               byte_n  = 3'd0;
               state_n = START;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (baud_done) begin
               baud_n  = '0;
               bit_n   = 3'd0;
               state_n = DATA;
            end else begin
               baud_n = baud + 1'b1;
            end
         end
         DATA: begin
            tx_d = shreg[{3'b111, bit_idx}];
            if (baud_done) begin
               baud_n = '0;
               if (bit_idx == 3'd7) state_n = STOP;
               else                 bit_n   = bit_idx + 3'd1;
            end else begin
               baud_n = baud + 1'b1;
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_n = '0;
               if (byte_idx == 3'd7) begin
                  state_n = IDLE;
               end else begin
                  byte_n  = byte_idx + 3'd1;
                  shreg_n = {shreg[55:0], 8'h00};
                  state_n = START;
               end
            end else begin
               baud_n = baud + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // tx is registered so the line never glitches and idles high out of reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         baud     <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_n;
         baud     <= baud_n;
         bit_idx  <= bit_n;
         byte_idx <= byte_n;
         shreg    <= shreg_n;
         tx       <= tx_d;
      end
   end

endmodule

// File: tb/tb_trace_uart_tx.sv
// Bench for trace_uart_tx: frame-level reference model plus an independent
// serial receiver decoding the tx line back into trace entries.
module tb_trace_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int ENTRY = 80 * CPB;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic trace_valid = 1'b0;
   logic [31:0] trace_pc = '0;
   logic [31:0] trace_instr = '0;
   logic tx, busy, overflow;
   logic [AW:0] fifo_count;

   trace_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH(DEPTH),
      .ADDR_W(AW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .trace_valid(trace_valid),
      .trace_pc(trace_pc),
      .trace_instr(trace_instr),
      .tx(tx),
      .busy(busy),
      .overflow(overflow),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference model: stored entries, remaining frame time, serial phase
   logic [63:0] mq[$];
   logic [63:0] sent_q[$];
   logic [63:0] cur;
   int rem, phase;
   bit active, movf;

   // receiver
   logic [63:0] rxq[$];
   bit rx_on;
   int rx_t, rx_nb;
   logic [7:0] rx_byte;
   logic [63:0] rx_ent;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic fbit(input logic [63:0] e, input int j);
      int f, bi, pos;
      logic [7:0] b;
      f   = j / CPB;
      bi  = f / 10;
      pos = f % 10;
      b   = 8'(e >> (56 - 8 * bi));
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return b[pos-1];
   endfunction

   task automatic model_clear();
      mq.delete();
      rem = 0;
      phase = 0;
      active = 1'b0;
      movf = 1'b0;
      rx_on = 1'b0;
      rx_t = 0;
      rx_nb = 0;
      rx_ent = '0;
      rx_byte = '0;
   endtask

   task automatic rx_tick();
      int b;
      if (!rx_on) begin
         if (tx == 1'b0) begin
            rx_on = 1'b1;
            rx_t = 0;
         end
      end else begin
         rx_t++;
      end
      if (rx_on && (rx_t % CPB) == CPB / 2) begin
         b = rx_t / CPB;
         if (b == 0) begin
            check("rx_start", 64'(tx), 64'(0));
         end else if (b <= 8) begin
            rx_byte[b-1] = tx;
         end else begin
            check("rx_stop", 64'(tx), 64'(1));
            rx_on = 1'b0;
            rx_ent = {rx_ent[55:0], rx_byte};
            rx_nb++;
            if (rx_nb == 8) begin
               rxq.push_back(rx_ent);
               rx_nb = 0;
            end
         end
      end
   endtask

   task automatic step(input logic v, input logic [31:0] pc,
                       input logic [31:0] ins);
      int size0;
      bit full, pop;
      logic txe;
      trace_valid = v;
      trace_pc = pc;
      trace_instr = ins;
      @(posedge clk);
      if (!reset) begin
         model_clear();
      end else begin
         size0 = mq.size();
         full = (size0 == DEPTH);
         pop = (rem == 0) && (size0 != 0);
         if (rem > 0) rem--;
         if (active) begin
            phase++;
            if (phase > ENTRY) active = 1'b0;
         end
         if (pop) begin
            cur = mq.pop_front();
            sent_q.push_back(cur);
            rem = ENTRY;
            phase = 0;
            active = 1'b1;
         end
         if (v) begin
            if (full) movf = 1'b1;
            else mq.push_back({pc, ins});
         end
      end
      #1;
      txe = (active && phase >= 1) ? fbit(cur, phase - 1) : 1'b1;
      check("tx", 64'(tx), 64'(txe));
      check("busy", 64'(busy), 64'(rem != 0 || mq.size() != 0));
      check("fifo_count", 64'(fifo_count), 64'(mq.size()));
      check("overflow", 64'(overflow), 64'(movf));
      if (reset) rx_tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom);
   endtask

   task automatic drain();
      int n = 0;
      while ((busy || active || rem != 0) && n < 5000) begin
         step(1'b0, $urandom, $urandom);
         n++;
      end
      check("drain_timeout", 64'(n < 5000), 64'(1));
      idle(4);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] ins_a[10];
   logic [31:0] pc_a[10];
   int n;

   initial begin
      model_clear();
      sent_q.delete();
      rxq.delete();

      // reset held: strobes ignored
      for (int i = 0; i < 6; i++) step(1'(i % 2 == 0), $urandom, $urandom);
      check("rst_tx", 64'(tx), 64'(1));
      check("rst_cnt", 64'(fifo_count), 64'(0));
      reset = 1'b1;
      idle(2);

      // single entry, latency and busy duration
      rxq.delete();
      step(1'b1, 32'h0000_0004, 32'h0050_0113);
      step(1'b0, $urandom, $urandom);
      check("lat_k1", 64'(tx), 64'(1));
      step(1'b0, $urandom, $urandom);
      check("lat_k2", 64'(tx), 64'(0));
      n = 2;
      while (busy && n < 400) begin
         step(1'b0, $urandom, $urandom);
         n++;
      end
      check("busy_fall", 64'(n), 64'(321));
      idle(4);
      check("single_cnt", 64'(fifo_count), 64'(0));
      check("single_n", 64'(rxq.size()), 64'(1));
      if (rxq.size() >= 1)
         check("single_ent", rxq[0], 64'h0000_0004_0050_0113);

      // burst of 6: one dropped
      rxq.delete();
      for (int i = 0; i < 6; i++) begin
         ins_a[i] = $urandom;
         step(1'b1, 32'(i * 4), ins_a[i]);
      end
      check("burst_ovf", 64'(overflow), 64'(1));
      drain();
      check("burst_ovf_sticky", 64'(overflow), 64'(1));
      check("burst_n", 64'(rxq.size()), 64'(5));
      for (int i = 0; i < 5; i++)
         if (i < rxq.size())
            check("burst_ent", rxq[i], {32'(i * 4), ins_a[i]});

      // push and pop on the same edge
      rxq.delete();
      ins_a[0] = $urandom;
      ins_a[1] = $urandom;
      step(1'b1, 32'h100, ins_a[0]);
      check("pp_pre", 64'(fifo_count), 64'(1));
      step(1'b1, 32'h104, ins_a[1]);
      check("pp_cnt", 64'(fifo_count), 64'(1));
      drain();
      check("pp_n", 64'(rxq.size()), 64'(2));
      if (rxq.size() >= 2) begin
         check("pp_ent0", rxq[0], {32'h100, ins_a[0]});
         check("pp_ent1", rxq[1], {32'h104, ins_a[1]});
      end

      // reset during a data bit of byte 3
      step(1'b1, $urandom, $urandom);
      idle(2 + 34 * CPB);
      #2;
      reset = 1'b0;
      #1;
      check("mid_tx", 64'(tx), 64'(1));
      check("mid_cnt", 64'(fifo_count), 64'(0));
      check("mid_busy", 64'(busy), 64'(0));
      check("mid_ovf", 64'(overflow), 64'(0));
      model_clear();
      rxq.delete();
      idle(3);
      reset = 1'b1;
      idle(1);
      pc_a[0] = $urandom;
      ins_a[0] = $urandom;
      step(1'b1, pc_a[0], ins_a[0]);
      drain();
      check("mid_n", 64'(rxq.size()), 64'(1));
      if (rxq.size() >= 1) check("mid_ent", rxq[0], {pc_a[0], ins_a[0]});

      // ten entries spaced one frame apart: pointer wrap
      rxq.delete();
      for (int i = 0; i < 10; i++) begin
         pc_a[i] = $urandom;
         ins_a[i] = $urandom;
         step(1'b1, pc_a[i], ins_a[i]);
         idle(ENTRY - 1);
         check("wrap_ovf", 64'(overflow), 64'(0));
      end
      drain();
      check("wrap_n", 64'(rxq.size()), 64'(10));
      for (int i = 0; i < 10; i++)
         if (i < rxq.size())
            check("wrap_ent", rxq[i], {pc_a[i], ins_a[i]});

      // random strobes against the model's transmit log
      rxq.delete();
      sent_q.delete();
      for (int i = 0; i < 600; i++)
         step(1'($urandom_range(0, 7) == 0), $urandom, $urandom);
      drain();
      check("rand_n", 64'(rxq.size()), 64'(sent_q.size()));
      for (int i = 0; i < sent_q.size(); i++)
         if (i < rxq.size()) check("rand_ent", rxq[i], sent_q[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/trace_uart_tx.md
Name: trace_uart_tx

Overview:
- Hardware counterpart to the processor's debug outputs: consumes the per-instruction debug stream (PC and instruction word) and transmits it off-chip over a UART TX line.
- Lets a board run be traced the same way the simulation bench monitors it.
- Sits beside the single-cycle core at top level:
  - trace_pc is wired to debug_pc.
  - trace_instr is wired to debug_instruction.
  - trace_valid asserts once per retired instruction.
- Internal FIFO decouples the one-instruction-per-cycle stream from the slow serial link.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 8, trace entries buffered; power of two, >= 2.
- ADDR_W, 3, log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- trace_valid  input  1  capture strobe: trace_pc/trace_instr valid this cycle.
- trace_pc  input  32  PC of retired instruction.
- trace_instr  input  32  instruction word at trace_pc.
- tx  output  1  UART serial line, idle high, 8N1.
- busy  output  1  1 while the FIFO is non-empty or a frame is in flight.
- overflow  output  1  sticky: a capture was dropped because the FIFO was full.
- fifo_count  output  ADDR_W+1  entries currently stored (0..FIFO_DEPTH).

Behaviour:
- Reset (reset=0, any time, asynchronous):
  - tx=1, busy=0, overflow=0, fifo_count=0.
  - FSM returns to IDLE; FIFO pointers and bit/byte/baud counters cleared.
  - A frame in progress is abandoned; tx returns high immediately.
- Capture:
  - On a rising edge with trace_valid=1 and FIFO not full, {trace_pc, trace_instr} (64 b) is written and fifo_count increments.
  - If the FIFO is full (including full at the same edge as a pop), the entry is dropped and overflow is set. Full-at-edge is evaluated before that edge's pop.
  - overflow clears only on reset.
- Simultaneous write and pop on the same edge: fifo_count unchanged; both operations take effect.
- Pointers are ADDR_W bits and wrap modulo FIFO_DEPTH. Full/empty is derived from fifo_count.
- FSM states and transitions:
  - IDLE: tx=1. If fifo_count != 0, pop the head into a 64-bit shift register, byte_idx=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx = current byte bit bit_idx, LSB first, CLKS_PER_BIT cycles each. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - byte_idx<7: byte_idx++, go to START (no idle gap between bytes of an entry).
    - byte_idx=7: go to IDLE.
- Byte order per entry: pc[31:24], pc[23:16], pc[15:8], pc[7:0], instr[31:24], instr[23:16], instr[15:8], instr[7:0].
- Timing:
  - One entry = 8 bytes x 10 bits x CLKS_PER_BIT cycles.
  - Between entries there is exactly 1 idle-high cycle (the IDLE pop cycle).
  - Latency: with the FSM in IDLE and the FIFO empty, an entry captured at edge k causes tx to go low on edge k+2.
- busy = (state != IDLE) || (fifo_count != 0); registered-equivalent, no glitches.
- Baud counter counts 0..CLKS_PER_BIT-1 and is reset on every state change.
- trace_pc/trace_instr are sampled only on capture edges; changes at other times are ignored.

Test Plan:
- Bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4, ADDR_W=2; one entry = 320 cycles.
- Reset check: hold reset=0, toggle trace_valid -> tx=1, busy=0, overflow=0, fifo_count=0; nothing captured.
- Single entry: trace_pc=0x00000004, trace_instr=0x00500113, one-cycle strobe -> tx low 2 edges later.
  - Decoded bytes: 00 00 00 04 00 50 01 13, each start=0/stop=1.
  - busy falls 321 cycles after capture; fifo_count returns to 0.
- Burst with overflow: strobe 6 consecutive cycles with PC 0x00,0x04,...,0x14 -> first entry popped while the rest fill the FIFO; 5 entries kept, 1 dropped.
  - overflow=1 and stays 1.
  - Serial output: PCs 0x00,0x04,0x08,0x0C,0x10; 0x14 never sent.
- Simultaneous push/pop: FIFO holds 1 entry, FSM in IDLE, strobe on the pop edge -> fifo_count stays 1; both entries transmitted in order, separated by exactly 1 idle cycle.
- Wrap-around: 10 entries spaced 320 cycles apart -> all 10 received intact and in order; overflow=0 throughout.
- Reset mid-frame: assert reset during the DATA bit of byte 3 -> tx=1 immediately, fifo_count=0, busy=0; after release the next strobe produces a clean frame starting with a start bit.
